// File: rtl/npu_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : npu_layer_sequencer
// Desc     : Command-driven sequencer for the NPU matrix engines. Layer
//            commands queue in a small FIFO. Each command is popped in
//            turn, its configuration is placed on the shared bus, the
//            selected engine gets a one-cycle start, and the sequencer
//            waits for a fresh done edge. A watchdog flags engines that
//            never finish, and a reserved opcode is rejected.
// Revision : 1.0 - initial release
// ============================================================================
module npu_layer_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_enable,
    // command push interface
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [1:0]  i_cmd_opcode,
    input  logic [13:0] i_cmd_src1_addr,
    input  logic [13:0] i_cmd_dest_addr,
    input  logic [9:0]  i_cmd_src1_row,
    input  logic [9:0]  i_cmd_src1_col,
    input  logic [5:0]  i_cmd_src2_row,
    input  logic [5:0]  i_cmd_src2_col,
    // engine bank
    output logic [2:0]  o_eng_start,
    input  logic [2:0]  i_eng_done,
    output logic [13:0] o_src1_start_address,
    output logic [13:0] o_dest_start_address,
    output logic [9:0]  o_src1_row_size,
    output logic [9:0]  o_src1_col_size,
    output logic [5:0]  o_src2_row_size,
    output logic [5:0]  o_src2_col_size,
    // status
    output logic        o_busy,
    output logic [4:0]  o_fifo_count,
    output logic        o_op_done,
    output logic [15:0] o_retired_count,
    output logic        o_err,
    output logic [1:0]  o_err_code,
    input  logic        i_err_clear
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int                 c_PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);
    localparam logic [4:0]         c_DEPTH     = 5'(FIFO_DEPTH);
    localparam logic [19:0]        c_TMO_LAST  = 20'(TIMEOUT - 1);
    localparam logic [1:0]         c_OP_ILLEGAL = 2'd3;
    localparam logic [1:0]         c_ERR_TMO   = 2'd1;
    localparam logic [1:0]         c_ERR_OPC   = 2'd2;

    typedef struct packed {
        logic [1:0]  opcode;
        logic [13:0] src1_addr;
        logic [13:0] dest_addr;
        logic [9:0]  src1_row;
        logic [9:0]  src1_col;
        logic [5:0]  src2_row;
        logic [5:0]  src2_col;
    } cmd_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_START  = 3'd2,
        S_WAIT   = 3'd3,
        S_RETIRE = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_nxt;

    cmd_t               r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [4:0]         r_count;
    cmd_t               w_cmd_in;
    cmd_t               w_head;
    logic               w_push;
    logic               w_pop;

    logic               w_load;
    logic               w_illegal;
    logic               w_timeout;
    logic               w_retire;
    logic               w_clr_err;
    logic               w_done_rise;

    logic [2:0]         r_op_sel;      // one-hot engine select of the in-flight op
    logic [2:0]         r_eng_start;
    logic [2:0]         r_done_prev;
    logic [19:0]        r_wait_cnt;
    logic               r_op_done;
    logic [15:0]        r_retired;
    logic               r_err;
    logic [1:0]         r_err_code;

    logic [13:0]        r_src1_addr;
    logic [13:0]        r_dest_addr;
    logic [9:0]         r_src1_row;
    logic [9:0]         r_src1_col;
    logic [5:0]         r_src2_row;
    logic [5:0]         r_src2_col;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    assign w_cmd_in = '{opcode:    i_cmd_opcode,
                        src1_addr: i_cmd_src1_addr,
                        dest_addr: i_cmd_dest_addr,
                        src1_row:  i_cmd_src1_row,
                        src1_col:  i_cmd_src1_col,
                        src2_row:  i_cmd_src2_row,
                        src2_col:  i_cmd_src2_col};

    // Ready depends only on the current count, so a full FIFO refuses a
    // push even on the cycle it is being popped.
    assign o_cmd_ready = (r_count < c_DEPTH);
    assign w_push      = i_cmd_valid & o_cmd_ready;
    assign w_head      = r_mem[r_rd_ptr];

    // Storage array; emptiness is governed by the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_cmd_in;
        end
    end

    // Pointer and occupancy tracking; simultaneous push and pop cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= 5'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 5'd1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 5'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    // Only a fresh rising edge on the selected engine's done counts, so a
    // level held over from a previous op or another engine's done is ignored.
    assign w_done_rise = |(i_eng_done & ~r_done_prev & r_op_sel);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and per-state control strobes
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        w_illegal   = 1'b0;
        w_timeout   = 1'b0;
        w_retire    = 1'b0;
        w_clr_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_enable && (r_count != 5'd0)) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                // The head is consumed whether or not it is legal.
                w_pop = 1'b1;
                if (w_head.opcode == c_OP_ILLEGAL) begin
                    w_illegal   = 1'b1;
                    w_state_nxt = S_ERROR;
                end else begin
                    w_load      = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // A done edge on the same cycle as the watchdog expiry wins.
                if (w_done_rise) begin
                    w_retire    = 1'b1;
                    w_state_nxt = S_RETIRE;
                end else if (r_wait_cnt == c_TMO_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_ERROR;
                end
            end
            S_RETIRE: begin
                w_state_nxt = S_IDLE;
            end
            S_ERROR: begin
                if (i_err_clear) begin
                    w_clr_err   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    // Configuration bus: captured on LOAD only and held for the whole op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src1_addr <= 14'd0;
            r_dest_addr <= 14'd0;
            r_src1_row  <= 10'd0;
            r_src1_col  <= 10'd0;
            r_src2_row  <= 6'd0;
            r_src2_col  <= 6'd0;
            r_op_sel    <= 3'b000;
        end else if (w_load) begin
            r_src1_addr <= w_head.src1_addr;
            r_dest_addr <= w_head.dest_addr;
            r_src1_row  <= w_head.src1_row;
            r_src1_col  <= w_head.src1_col;
            r_src2_row  <= w_head.src2_row;
            r_src2_col  <= w_head.src2_col;
            r_op_sel    <= 3'b001 << w_head.opcode;
        end
    end

    // Engine start pulse: raised on the LOAD edge, dropped one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_eng_start <= 3'b000;
        end else if (w_load) begin
            r_eng_start <= 3'b001 << w_head.opcode;
        end else begin
            r_eng_start <= 3'b000;
        end
    end

    // Previous done sample for edge detection, and the watchdog counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done_prev <= 3'b000;
            r_wait_cnt  <= 20'd0;
        end else begin
            r_done_prev <= i_eng_done;
            if (r_state == S_START) begin
                r_wait_cnt <= 20'd0;
            end else if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 20'd1;
            end
        end
    end

    // Retirement pulse and wrapping retirement counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_done <= 1'b0;
            r_retired <= 16'd0;
        end else begin
            r_op_done <= w_retire;
            if (w_retire) begin
                r_retired <= r_retired + 16'd1;
            end
        end
    end

    // Error flag and code, held until the host clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err      <= 1'b0;
            r_err_code <= 2'd0;
        end else if (w_illegal) begin
            r_err      <= 1'b1;
            r_err_code <= c_ERR_OPC;
        end else if (w_timeout) begin
            r_err      <= 1'b1;
            r_err_code <= c_ERR_TMO;
        end else if (w_clr_err) begin
            r_err      <= 1'b0;
            r_err_code <= 2'd0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_eng_start          = r_eng_start;
    assign o_src1_start_address = r_src1_addr;
    assign o_dest_start_address = r_dest_addr;
    assign o_src1_row_size      = r_src1_row;
    assign o_src1_col_size      = r_src1_col;
    assign o_src2_row_size      = r_src2_row;
    assign o_src2_col_size      = r_src2_col;
    assign o_busy               = (r_state != S_IDLE);
    assign o_fifo_count         = r_count;
    assign o_op_done            = r_op_done;
    assign o_retired_count      = r_retired;
    assign o_err                = r_err;
    assign o_err_code           = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_npu_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_npu_layer_sequencer
// Desc     : Self-checking bench for npu_layer_sequencer. A command queue
//            model predicts start order, configuration and retirement;
//            directed steps cover timing, back-pressure, watchdog, illegal
//            opcodes, stale done levels and reset, followed by random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_npu_layer_sequencer;

    localparam int c_DEPTH = 4;
    localparam int c_TMO   = 16;

    typedef struct packed {
        logic [1:0]  op;
        logic [13:0] s1a;
        logic [13:0] da;
        logic [9:0]  r1;
        logic [9:0]  c1;
        logic [5:0]  r2;
        logic [5:0]  c2;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        cmd_valid;
    cmd_t        cmd;
    logic [2:0]  eng_done;
    logic        err_clear;

    logic        cmd_ready;
    logic [2:0]  eng_start;
    logic [13:0] s1a_o;
    logic [13:0] da_o;
    logic [9:0]  r1_o;
    logic [9:0]  c1_o;
    logic [5:0]  r2_o;
    logic [5:0]  c2_o;
    logic        busy;
    logic [4:0]  fifo_count;
    logic        op_done;
    logic [15:0] retired;
    logic        err;
    logic [1:0]  err_code;

    always #5 clk = ~clk;

    npu_layer_sequencer #(
        .FIFO_DEPTH (c_DEPTH),
        .TIMEOUT    (c_TMO)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .i_enable             (en),
        .i_cmd_valid          (cmd_valid),
        .o_cmd_ready          (cmd_ready),
        .i_cmd_opcode         (cmd.op),
        .i_cmd_src1_addr      (cmd.s1a),
        .i_cmd_dest_addr      (cmd.da),
        .i_cmd_src1_row       (cmd.r1),
        .i_cmd_src1_col       (cmd.c1),
        .i_cmd_src2_row       (cmd.r2),
        .i_cmd_src2_col       (cmd.c2),
        .o_eng_start          (eng_start),
        .i_eng_done           (eng_done),
        .o_src1_start_address (s1a_o),
        .o_dest_start_address (da_o),
        .o_src1_row_size      (r1_o),
        .o_src1_col_size      (c1_o),
        .o_src2_row_size      (r2_o),
        .o_src2_col_size      (c2_o),
        .o_busy               (busy),
        .o_fifo_count         (fifo_count),
        .o_op_done            (op_done),
        .o_retired_count      (retired),
        .o_err                (err),
        .o_err_code           (err_code),
        .i_err_clear          (err_clear)
    );

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    int          checks         = 0;
    int          failures       = 0;
    cmd_t        model_q[$];          // commands pushed and not yet consumed
    logic [2:0]  start_q[$];          // observed start vectors
    logic [59:0] cfg_q[$];            // observed config bus at each start
    int          n_started      = 0;
    int          exp_retired    = 0;
    int          exp_done_total = 0;
    logic [59:0] last_cfg       = '0;
    int          op_done_cnt    = 0;
    int          long_starts    = 0;
    logic [2:0]  prev_start     = 3'b000;

    // Observer: logs every start cycle and counts op_done pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (eng_start != 3'b000) begin
                start_q.push_back(eng_start);
                cfg_q.push_back({s1a_o, da_o, r1_o, c1_o, r2_o, c2_o});
                if (prev_start != 3'b000) begin
                    long_starts <= long_starts + 1;
                end
            end
            if (op_done) begin
                op_done_cnt <= op_done_cnt + 1;
            end
        end
        prev_start <= eng_start;
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [59:0] cfg_of(input cmd_t c);
        return {c.s1a, c.da, c.r1, c.c1, c.r2, c.c2};
    endfunction

    function automatic cmd_t rand_cmd(input logic [1:0] op);
        cmd_t c;
        c.op  = op;
        c.s1a = 14'($urandom);
        c.da  = 14'($urandom);
        c.r1  = 10'($urandom);
        c.c1  = 10'($urandom);
        c.r2  = 6'($urandom);
        c.c2  = 6'($urandom);
        return c;
    endfunction

    task automatic push_cmd(input cmd_t c);
        int n = 0;
        cmd_valid = 1'b1;
        cmd       = c;
        while (cmd_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("push_ready_bound", 64'(cmd_ready), 64'd1);
        tick();
        cmd_valid = 1'b0;
        model_q.push_back(c);
    endtask

    task automatic expect_start(input string tag, output logic [1:0] op);
        int          n = 0;
        cmd_t        h;
        logic [2:0]  exp_oh;
        while (start_q.size() <= n_started && n < 60) begin
            tick();
            n++;
        end
        check({tag, "_seen"}, 64'(start_q.size() > n_started), 64'd1);
        op = 2'd0;
        if (model_q.size() != 0) begin
            h      = model_q.pop_front();
            op     = h.op;
            exp_oh = 3'b001 << h.op;
            if (start_q.size() > n_started) begin
                check({tag, "_onehot"}, 64'(start_q[n_started]), 64'(exp_oh));
                check({tag, "_cfg"}, 64'(cfg_q[n_started]), 64'(cfg_of(h)));
                n_started++;
            end
            last_cfg = cfg_of(h);
        end
    endtask

    task automatic wait_retire(input string tag);
        int n = 0;
        while (op_done_cnt <= exp_done_total && n < 40) begin
            tick();
            n++;
        end
        exp_done_total++;
        exp_retired++;
        check({tag, "_op_done"}, 64'(op_done_cnt), 64'(exp_done_total));
        tick();
        check({tag, "_retired"}, 64'(retired), 64'(exp_retired));
    endtask

    task automatic respond(input string tag, input logic [1:0] op, input int delay);
        repeat (delay) tick();
        eng_done[op] = 1'b1;
        tick();
        eng_done[op] = 1'b0;
        wait_retire(tag);
    endtask

    task automatic expect_illegal(input string tag);
        int   n = 0;
        cmd_t h;
        while (err !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        check({tag, "_err"}, 64'(err), 64'd1);
        check({tag, "_code"}, 64'(err_code), 64'd2);
        check({tag, "_no_start"}, 64'(start_q.size()), 64'(n_started));
        check({tag, "_cfg_held"}, 64'({s1a_o, da_o, r1_o, c1_o, r2_o, c2_o}), 64'(last_cfg));
        if (model_q.size() != 0) begin
            h = model_q.pop_front();
            check({tag, "_model_op"}, 64'(h.op), 64'd3);
        end
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check({tag, "_err_cleared"}, 64'(err), 64'd0);
        check({tag, "_code_cleared"}, 64'(err_code), 64'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ready"}, 64'(cmd_ready), 64'd1);
        check({tag, "_start"}, 64'(eng_start), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_count"}, 64'(fifo_count), 64'd0);
        check({tag, "_op_done"}, 64'(op_done), 64'd0);
        check({tag, "_retired"}, 64'(retired), 64'd0);
        check({tag, "_err"}, 64'({err, err_code}), 64'd0);
        check({tag, "_cfg"}, 64'({s1a_o, da_o, r1_o, c1_o, r2_o, c2_o}), 64'd0);
    endtask

    // ------------------------------------------------------------------
    // Directed and random sequence
    // ------------------------------------------------------------------
    initial begin
        cmd_t       c;
        logic [1:0] op;
        int         k;
        int         r;

        rst_n     = 1'b0;
        en        = 1'b0;
        cmd_valid = 1'b0;
        cmd       = '0;
        eng_done  = 3'b000;
        err_clear = 1'b0;
        tick();
        tick();
        check_reset_state("reset");
        rst_n = 1'b1;
        tick();

        // ---- single maxpool with cycle-exact timing ----
        en = 1'b1;
        c  = '{op: 2'd0, s1a: 14'd0, da: 14'd0, r1: 10'd26, c1: 10'd26, r2: 6'd2, c2: 6'd2};
        push_cmd(c);                                   // E0
        check("mp_e0_count", 64'(fifo_count), 64'd1);
        check("mp_e0_busy", 64'(busy), 64'd0);
        tick();                                        // E1
        check("mp_e1_busy", 64'(busy), 64'd1);
        check("mp_e1_start", 64'(eng_start), 64'd0);
        tick();                                        // E2
        check("mp_e2_start", 64'(eng_start), 64'b001);
        check("mp_e2_rows", 64'({r1_o, c1_o, r2_o, c2_o}), 64'({10'd26, 10'd26, 6'd2, 6'd2}));
        check("mp_e2_count", 64'(fifo_count), 64'd0);
        expect_start("mp", op);
        tick();                                        // E3
        check("mp_e3_start", 64'(eng_start), 64'd0);
        eng_done[0] = 1'b1;
        tick();                                        // E4
        check("mp_e4_op_done", 64'(op_done), 64'd1);
        eng_done[0] = 1'b0;
        tick();                                        // E5
        check("mp_e5_op_done", 64'(op_done), 64'd0);
        check("mp_e5_busy", 64'(busy), 64'd0);
        check("mp_e5_retired", 64'(retired), 64'd1);
        exp_retired    = 1;
        exp_done_total = 1;
        check("mp_op_done_cnt", 64'(op_done_cnt), 64'd1);

        // ---- back-to-back with a full FIFO ----
        en = 1'b0;
        push_cmd(rand_cmd(2'd0));
        push_cmd(rand_cmd(2'd1));
        push_cmd(rand_cmd(2'd2));
        push_cmd(rand_cmd(2'd0));
        check("b2b_full_count", 64'(fifo_count), 64'd4);
        check("b2b_full_ready", 64'(cmd_ready), 64'd0);
        c         = rand_cmd(2'd1);
        cmd_valid = 1'b1;
        cmd       = c;
        tick();
        tick();
        tick();
        check("b2b_refused_count", 64'(fifo_count), 64'd4);
        check("b2b_no_start_disabled", 64'(start_q.size()), 64'(n_started));
        check("b2b_idle_disabled", 64'(busy), 64'd0);
        en = 1'b1;
        push_cmd(c);
        check("b2b_after_pop_count", 64'(fifo_count), 64'd4);
        for (int i = 0; i < 5; i++) begin
            expect_start("b2b", op);
            respond("b2b", op, int'($urandom_range(1, 4)));
        end

        // ---- watchdog timeout ----
        push_cmd(rand_cmd(2'd2));
        push_cmd(rand_cmd(2'd0));
        expect_start("tmo", op);
        repeat (c_TMO) tick();
        check("tmo_not_yet", 64'(err), 64'd0);
        tick();
        check("tmo_err", 64'(err), 64'd1);
        check("tmo_code", 64'(err_code), 64'd1);
        check("tmo_busy", 64'(busy), 64'd1);
        check("tmo_queued", 64'(fifo_count), 64'd1);
        push_cmd(rand_cmd(2'd1));
        check("tmo_push_in_error", 64'(fifo_count), 64'd2);
        check("tmo_no_retire", 64'(op_done_cnt), 64'(exp_done_total));
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("tmo_cleared", 64'({err, err_code}), 64'd0);
        expect_start("tmo_next", op);
        respond("tmo_next", op, 2);
        expect_start("tmo_next2", op);
        respond("tmo_next2", op, 3);

        // ---- illegal opcode ----
        push_cmd(rand_cmd(2'd3));
        push_cmd(rand_cmd(2'd1));
        expect_illegal("illegal");
        expect_start("illegal_next", op);
        respond("illegal_next", op, 1);

        // ---- stale and foreign done ----
        eng_done[0] = 1'b1;
        tick();
        push_cmd(rand_cmd(2'd0));
        expect_start("stale", op);
        tick();
        tick();
        eng_done[1] = 1'b1;
        err_clear   = 1'b1;
        tick();
        eng_done[1] = 1'b0;
        err_clear   = 1'b0;
        tick();
        tick();
        check("stale_no_retire", 64'(op_done_cnt), 64'(exp_done_total));
        check("stale_busy", 64'(busy), 64'd1);
        check("stale_clear_ignored", 64'(err), 64'd0);
        eng_done[0] = 1'b0;
        tick();
        eng_done[0] = 1'b1;
        tick();
        eng_done[0] = 1'b0;
        wait_retire("stale");

        // ---- random traffic ----
        for (int it = 0; it < 15; it++) begin
            k = int'($urandom_range(1, 3));
            for (int j = 0; j < k; j++) begin
                r = int'($urandom_range(0, 7));
                push_cmd(rand_cmd((r == 7) ? 2'd3 : 2'(r % 3)));
            end
            while (model_q.size() != 0) begin
                if (model_q[0].op == 2'd3) begin
                    expect_illegal("rnd_illegal");
                end else begin
                    expect_start("rnd", op);
                    respond("rnd", op, int'($urandom_range(1, 8)));
                end
            end
        end

        // ---- reset mid-WAIT with two queued ----
        push_cmd(rand_cmd(2'd1));
        push_cmd(rand_cmd(2'd2));
        push_cmd(rand_cmd(2'd0));
        expect_start("rst", op);
        tick();
        tick();
        check("rst_queued", 64'(fifo_count), 64'd2);
        check("rst_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset_state("rst_mid");
        model_q.delete();
        exp_retired = 0;
        last_cfg    = '0;
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("rst_no_start", 64'(start_q.size()), 64'(n_started));
        check("rst_no_op_done", 64'(op_done_cnt), 64'(exp_done_total));
        check("rst_idle", 64'({busy, fifo_count}), 64'd0);
        push_cmd(rand_cmd(2'd2));
        expect_start("post_rst", op);
        respond("post_rst", op, 2);

        check("start_width", 64'(long_starts), 64'd0);
        check("start_total", 64'(start_q.size()), 64'(n_started));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/npu_layer_sequencer.md
# npu_layer_sequencer

Command-driven controller that sequences the NPU's matrix engines (max-pool, matrix add, convolution) one operation at a time. The host pushes layer commands into a small FIFO. The sequencer pops each command, drives the shared configuration bus, pulses the selected engine's `start`, and waits for its `done`. A watchdog flags engines that never finish. The block sits between the HPS/host command interface and the engine bank that shares the M10K source/destination SRAMs.

## Interface
- `FIFO_DEPTH`, 4: command FIFO entries (power of 2, 2..16).
- `TIMEOUT`, 1000000: max cycles in WAIT before timeout error (20-bit).
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `enable` in 1: permits popping new commands. An in-flight operation always completes.
- `cmd_valid` in 1 / `cmd_ready` out 1: command push handshake.
- `cmd_opcode` in 2: 0 = maxpool, 1 = add, 2 = conv, 3 = illegal.
- `cmd_src1_addr` in 14, `cmd_dest_addr` in 14: start addresses.
- `cmd_src1_row` in 10, `cmd_src1_col` in 10: source matrix size.
- `cmd_src2_row` in 6, `cmd_src2_col` in 6: window/kernel size.
- `eng_start` out 3: one-hot start, bit = opcode.
- `eng_done` in 3: engine done (level or pulse).
- `src1_start_address` out 14, `dest_start_address` out 14: shared configuration bus.
- `src1_row_size` out 10, `src1_col_size` out 10: shared configuration bus.
- `src2_row_size` out 6, `src2_col_size` out 6: shared configuration bus.
- `busy` out 1: state is not IDLE.
- `fifo_count` out 5: commands queued.
- `op_done` out 1: 1-cycle pulse per retired command.
- `retired_count` out 16: retired commands, wraps.
- `err` out 1, `err_code` out 2: error state; code 1 = timeout, 2 = illegal opcode.
- `err_clear` in 1: leave ERROR.

## Operation
- **Reset values:** every output is 0 except `cmd_ready` = 1. The FIFO is emptied, the state is IDLE, and counters are 0.
- **FIFO:** push when `cmd_valid & cmd_ready`. `cmd_ready = (fifo_count < FIFO_DEPTH)`. When full, a push is refused even if a pop occurs in the same cycle. Simultaneous push and pop in the non-full case leaves the count unchanged. Command order is preserved.
- **IDLE:** if `enable` and `fifo_count != 0`, go to LOAD.
- **LOAD:** pop the head. If the opcode is 3, go to ERROR with `err_code` = 2 and no start is issued. Otherwise register the head into the config outputs and `op_sel`, set `eng_start[op]` = 1, and go to START.
- **START:** `eng_start` is high this cycle only. Clear `wait_cnt` and go to WAIT.
- **WAIT:** `eng_start` = 0 and `wait_cnt` increments each cycle.
  - On a rising edge of `eng_done[op_sel]` (compared against the registered previous `eng_done`), go to RETIRE.
  - Else, if `wait_cnt == TIMEOUT-1`, go to ERROR with `err_code` = 1.
  - If done and timeout occur in the same cycle, done wins.
  - `eng_done` of non-selected engines is ignored.
- **RETIRE:** `op_done` = 1 for one cycle and `retired_count` increments. Go to IDLE.
- **ERROR:** `err` = 1 and `err_code` is held. The FIFO contents are retained and pushes are still accepted. On `err_clear`, clear `err` and `err_code` to 0 and go to IDLE. `err_clear` in any other state is ignored.
- **Config outputs:** change only on the LOAD edge and hold until the next LOAD, so engines may read them for the whole operation.
- **`enable` = 0 mid-operation:** the current command runs through RETIRE. No further LOAD occurs until `enable` returns to 1.
- **Reset mid-operation:** immediate return to reset values. The in-flight command and all queued commands are discarded.

## Timing
- Take E0 as the edge that accepts a command into an empty FIFO while in IDLE with `enable` = 1. Then:
  - E1: IDLE to LOAD.
  - E2: config registered and `eng_start` rises.
  - E3: `eng_start` falls.
  - The first done can be sampled at E4.
- **Engine requirement:** engines must accept a 1-cycle `start` with the config bus already stable.
- **Done to next start:** a done edge sampled at edge D gives RETIRE at D, then IDLE at D+1. The next command gets LOAD at D+2 and `eng_start` at D+3. So there is at least a 3-cycle gap between `done` and the next `start`.
- **Timeout latency:** ERROR is entered exactly `TIMEOUT` cycles after entering WAIT.
- **`fifo_count`:** reflects a push or pop on the edge it occurs.

## Test plan
- **Single maxpool:** push op 0, addr 0 / 0, 26x26, 2x2. Required: `eng_start` = 3'b001 for exactly 1 cycle, config bus = pushed values, engine `done` → `op_done` pulse, `retired_count` = 1, `busy` = 0.
- **Back-to-back mix:** push ops 0, 1, 2 (5 pushes total, depth 4, with no engine done returned yet). Required: the 5th push is stalled by `cmd_ready` = 0 until the first pop. Starts are issued in order 001, 010, 100, 001, 010. `retired_count` = 5.
- **Timeout:** `TIMEOUT` = 16, engine never signals done. Required: `err` = 1 and `err_code` = 1 exactly 16 cycles after entering WAIT. `err_clear` → IDLE, and the next queued command starts.
- **Illegal opcode:** push op 3, then op 1. Required: no `eng_start`, `err_code` = 2. After `err_clear`, op 1 starts.
- **Stale/foreign done:** hold `eng_done[0]` high before the op 0 start, and pulse `eng_done[1]` during WAIT. Required: no retire until a fresh rising edge on `eng_done[0]`.
- **Reset mid-WAIT with 2 commands queued:** drop `reset` low. Required: `eng_start` = 0, `fifo_count` = 0, `busy` = 0, `cmd_ready` = 1 immediately, with no `op_done`.
